// File: rtl/jump_input_conditioner.sv
// Conditions the raw jump/duck buttons: two-flop synchronizer, debounce, and a
// frame-aligned one-shot jump request held high for exactly one screen_end frame.
module jump_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CTR_WIDTH       = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       up,
   input  logic       down,
   input  logic       screen_end,
   output logic       io_jump,
   output logic       io_duck,
   output logic [7:0] jump_count
);
   localparam logic [CTR_WIDTH-1:0] CTR_LAST = CTR_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

   logic [1:0] w_raw;
   logic [1:0] w_stable;
   logic       w_up_synced;
   logic       w_up_rise;

   assign w_raw = {down, up};

   // Index 0 is the jump button, index 1 the duck button.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic                 r_s1;
      logic                 r_s;
      logic                 r_stable;
      logic [CTR_WIDTH-1:0] r_ctr;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_s1     <= 1'b0;
            r_s      <= 1'b0;
            r_stable <= 1'b0;
            r_ctr    <= '0;
         end else begin
            r_s1 <= w_raw[gi];
            r_s  <= r_s1;
            if (r_s == r_stable) begin
               r_ctr <= '0;
            end else if (r_ctr == CTR_LAST) begin
               r_stable <= r_s;
               r_ctr    <= '0;
            end else begin
               r_ctr <= r_ctr + 1'b1;
            end
         end
      end

      assign w_stable[gi] = r_stable;
   end

   assign w_up_synced = g_btn[0].r_s;

   logic       r_up_d;
   logic [1:0] r_sync_fill;
   logic       r_up_released;

   // A rise only counts once the button has been seen released since reset,
   // so a button still held across reset cannot fire a jump.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_up_d        <= 1'b0;
         r_sync_fill   <= 2'b00;
         r_up_released <= 1'b0;
      end else begin
         r_up_d      <= w_stable[0];
         r_sync_fill <= {r_sync_fill[0], 1'b1};
         if (r_sync_fill[1] && !w_up_synced && !w_stable[0]) begin
            r_up_released <= 1'b1;
         end
      end
   end

   assign w_up_rise = w_stable[0] & ~r_up_d & r_up_released;

   state_t     r_state;
   logic       r_jump;
   logic       r_duck;
   logic [7:0] r_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_jump  <= 1'b0;
         r_duck  <= 1'b0;
         r_count <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_jump <= 1'b0;
               r_duck <= w_stable[1];
               if (w_up_rise) r_state <= ARMED;
            end
            ARMED: begin
               if (screen_end) begin
                  r_state <= ACTIVE;
                  r_jump  <= 1'b1;
                  r_duck  <= 1'b0;
                  r_count <= r_count + 8'd1;
               end else begin
                  r_jump <= 1'b0;
                  r_duck <= w_stable[1];
               end
            end
            ACTIVE: begin
               if (screen_end) begin
                  r_state <= IDLE;
                  r_jump  <= 1'b0;
                  r_duck  <= w_stable[1];
               end else begin
                  r_jump <= 1'b1;
                  r_duck <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_jump  <= 1'b0;
               r_duck  <= 1'b0;
            end
         endcase
      end
   end

   assign io_jump    = r_jump;
   assign io_duck    = r_duck;
   assign jump_count = r_count;
endmodule

// File: tb/tb_jump_input_conditioner.sv
// Directed bench for jump_input_conditioner with a per-cycle behavioural model
// of debounce windows and frame-aligned jump requests.
`timescale 1ns/1ps
module tb_jump_input_conditioner;
   localparam int DB = 4;

   logic       clock      = 1'b0;
   logic       reset      = 1'b0;
   logic       up         = 1'b0;
   logic       down       = 1'b0;
   logic       screen_end = 1'b0;
   logic       io_jump;
   logic       io_duck;
   logic [7:0] jump_count;

   int n_checks = 0;
   int n_fail   = 0;

   jump_input_conditioner #(.DEBOUNCE_CYCLES(DB), .CTR_WIDTH(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .up         (up),
      .down       (down),
      .screen_end (screen_end),
      .io_jump    (io_jump),
      .io_duck    (io_duck),
      .jump_count (jump_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: raw samples per edge since reset; synced value seen at edge n is
   // the raw sample of edge n-2; stable flips when the last DB synced samples
   // all differ from it. A jump request waits for one frame tick, then lasts one frame.
   bit       ru[$];
   bit       rd[$];
   int       m_n;
   bit       m_stab_up, m_stab_up_d, m_stab_dn, m_released;
   bit       m_pending, m_active, m_jump, m_duck;
   bit [7:0] m_count;
   bit       t_rise, t_dn, t_rel, t_fu, t_fd;

   function automatic bit synced(input bit sel_down, input int n);
      if (n < 3) return 1'b0;
      return sel_down ? rd[n-3] : ru[n-3];
   endfunction

   function automatic bit settles(input bit sel_down, input int n, input bit stab);
      if (n < DB) return 1'b0;
      for (int j = 0; j < DB; j++)
         if (synced(sel_down, n - j) == stab) return 1'b0;
      return 1'b1;
   endfunction

   initial forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
         ru.delete();
         rd.delete();
         m_n = 0;
         m_stab_up = 0; m_stab_up_d = 0; m_stab_dn = 0; m_released = 0;
         m_pending = 0; m_active = 0; m_jump = 0; m_duck = 0; m_count = 0;
      end else begin
         m_n++;
         ru.push_back(up);
         rd.push_back(down);
         t_rise = m_stab_up && !m_stab_up_d && m_released;
         t_dn   = m_stab_dn;
         t_rel  = m_released || (m_n >= 3 && !synced(1'b0, m_n) && !m_stab_up);
         t_fu   = settles(1'b0, m_n, m_stab_up);
         t_fd   = settles(1'b1, m_n, m_stab_dn);
         m_released  = t_rel;
         m_stab_up_d = m_stab_up;
         if (t_fu) m_stab_up = !m_stab_up;
         if (t_fd) m_stab_dn = !m_stab_dn;
         if (m_active) begin
            if (screen_end) m_active = 0;
         end else if (m_pending) begin
            if (screen_end) begin
               m_pending = 0;
               m_active  = 1;
               m_count   = m_count + 8'd1;
            end
         end else if (t_rise) begin
            m_pending = 1;
         end
         m_jump = m_active;
         m_duck = t_dn && !m_active;
      end
   end

   initial forever begin
      @(negedge clock);
      chk("cyc_io_jump", io_jump, m_jump);
      chk("cyc_io_duck", io_duck, m_duck);
      chk("cyc_jump_count", jump_count, m_count);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic tick();
      screen_end = 1'b1;
      step();
      screen_end = 1'b0;
   endtask

   task automatic do_reset();
      up = 1'b0;
      down = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      #1 reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      repeat (4) step();
      chk("reset_jump", io_jump, 0);
      chk("reset_duck", io_duck, 0);
      chk("reset_count", jump_count, 0);

      // Basic press: edge numbering relative to the edge before up rises.
      up = 1'b1;
      repeat (7) step();
      chk("basic_armed_no_jump", io_jump, 0);
      repeat (2) step();
      tick();
      chk("basic_jump_hi", io_jump, 1);
      chk("basic_count", jump_count, 1);
      repeat (9) step();
      chk("basic_jump_held", io_jump, 1);
      tick();
      chk("basic_jump_lo", io_jump, 0);
      up = 1'b0;
      repeat (10) step();

      // Glitch shorter than the debounce window.
      do_reset();
      up = 1'b1;
      repeat (3) step();
      up = 1'b0;
      repeat (8) step();
      tick();
      repeat (5) step();
      tick();
      chk("glitch_jump", io_jump, 0);
      chk("glitch_count", jump_count, 0);

      // Second press during ACTIVE must not queue.
      do_reset();
      up = 1'b1;
      repeat (8) step();
      tick();
      chk("noq_active", io_jump, 1);
      up = 1'b0;
      repeat (8) step();
      up = 1'b1;
      repeat (9) step();
      chk("noq_still_active", io_jump, 1);
      tick();
      chk("noq_idle", io_jump, 0);
      repeat (10) step();
      tick();
      repeat (10) step();
      tick();
      repeat (3) step();
      chk("noq_jump", io_jump, 0);
      chk("noq_count", jump_count, 1);

      // up_rise coincides with screen_end in IDLE.
      do_reset();
      up = 1'b1;
      repeat (6) step();
      tick();
      chk("simul_jump", io_jump, 0);
      chk("simul_count", jump_count, 0);
      repeat (5) step();
      chk("simul_armed_wait", io_jump, 0);
      tick();
      chk("simul_jump_hi", io_jump, 1);
      chk("simul_count1", jump_count, 1);
      repeat (3) step();
      tick();
      chk("simul_jump_lo", io_jump, 0);
      up = 1'b0;
      repeat (10) step();

      // Jump takes priority over duck.
      do_reset();
      down = 1'b1;
      repeat (8) step();
      chk("duck_on", io_duck, 1);
      up = 1'b1;
      repeat (8) step();
      chk("duck_armed", io_duck, 1);
      tick();
      chk("duck_active_jump", io_jump, 1);
      chk("duck_active_off", io_duck, 0);
      repeat (5) step();
      chk("duck_active_off2", io_duck, 0);
      tick();
      chk("duck_exit_jump", io_jump, 0);
      chk("duck_resume", io_duck, 1);
      up = 1'b0;
      down = 1'b0;
      repeat (10) step();

      // Asynchronous reset in the middle of ACTIVE.
      do_reset();
      down = 1'b1;
      up = 1'b1;
      repeat (8) step();
      tick();
      chk("areset_pre_jump", io_jump, 1);
      chk("areset_pre_count", jump_count, 1);
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      chk("areset_jump", io_jump, 0);
      chk("areset_duck", io_duck, 0);
      chk("areset_count", jump_count, 0);
      step();
      step();
      reset = 1'b0;
      repeat (12) step();
      tick();
      repeat (5) step();
      tick();
      chk("areset_held_no_jump", io_jump, 0);
      chk("areset_held_count", jump_count, 0);
      up = 1'b0;
      repeat (8) step();
      up = 1'b1;
      repeat (8) step();
      tick();
      chk("areset_repress_jump", io_jump, 1);
      chk("areset_repress_count", jump_count, 1);
      tick();
      up = 1'b0;
      down = 1'b0;
      repeat (10) step();

      // jump_count wraps after 256 jumps.
      do_reset();
      for (int i = 1; i <= 256; i++) begin
         up = 1'b1;
         repeat (8) step();
         tick();
         up = 1'b0;
         repeat (7) step();
         tick();
         step();
         if (i == 255) chk("wrap_255", jump_count, 255);
      end
      chk("wrap_0", jump_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/jump_input_conditioner.md
Name: jump_input_conditioner

Overview:
Conditions the raw board push-buttons before they reach the processor's io_jump input.
- Synchronizes the raw `up`/`down` buttons, debounces them, and turns each up-press into exactly one frame-aligned jump request.
- Presents that request on io_jump for one full frame, delimited by the VGA controller's 60 Hz screen_end tick, so game code polling once per frame sees every press exactly once.
- Sits between the board pins and the processor/VGA in the top-level wrapper.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronized input must differ from its stable value before the stable value flips (10 ms at 100 MHz).
- CTR_WIDTH, 20: width of each debounce counter; must satisfy 2^CTR_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all flops on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- up  in  1  raw jump button, asynchronous to clock.
- down  in  1  raw duck button, asynchronous to clock.
- screen_end  in  1  one-cycle frame tick from the VGA controller, synchronous to clock.
- io_jump  out  1  jump request level to the processor; held high for exactly one frame.
- io_duck  out  1  debounced duck level.
- jump_count  out  8  number of jumps issued; debug only.

Behaviour:
- Reset (asynchronous, active-high):
  - all synchronizer, debounce and counter flops go to 0;
  - FSM goes to IDLE;
  - io_jump, io_duck and jump_count are 0 immediately, without waiting for a clock edge.
- Synchronizer: two flops per button (up_s1→up_s, down_s1→down_s). Synced value is valid 2 edges after a raw change.
- Debounce, per button, with a stable flop and a counter:
  - if synced == stable, counter <= 0;
  - otherwise counter increments;
  - on the edge where counter == DEBOUNCE_CYCLES-1, stable <= synced and counter <= 0.
  - Net: stable flips on the 2+DEBOUNCE_CYCLES-th edge after a clean raw change.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and never reaches stable.
- Rise detect: up_rise = stable_up & ~stable_up_d, where stable_up_d is a one-cycle delay of stable_up. up_rise is a single-cycle pulse.
- FSM states:
  - IDLE: io_jump=0. On up_rise → ARMED.
  - ARMED: io_jump=0, waiting for a frame boundary.
    - On screen_end → ACTIVE, and jump_count increments (wraps 255→0).
    - Further up_rise pulses are ignored; requests do not queue.
  - ACTIVE: io_jump=1.
    - On screen_end → IDLE.
    - up_rise during ACTIVE is dropped.
- io_jump is a registered state decode: it rises on the edge after the arming screen_end and falls on the edge after the next screen_end.
- Simultaneous up_rise and screen_end in IDLE: go to ARMED only; that screen_end is not consumed. The jump starts at the following screen_end.
- A press released before the arming screen_end still produces the jump: the request is latched at ARMED.
- io_duck <= stable_down & ~(next state == ACTIVE). Jump has priority: duck is forced 0 for the whole ACTIVE frame and resumes on the edge after ACTIVE exits if down is still held.
- Holding up never repeats a jump. A new jump requires stable_up to fall and rise again.
- Reset asserted mid-ARMED or mid-ACTIVE: the pending or active jump is discarded, with no residual request after reset release.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CTR_WIDTH=3):
- Basic press: raw up 0→1 at edge 0 and held.
  - stable_up=1 after edge 6; FSM ARMED after edge 7.
  - screen_end pulse at edge 10 → io_jump=1 after edge 10, jump_count=1.
  - next screen_end at edge 20 → io_jump=0 after edge 20.
- Glitch rejection: up high for 3 cycles, then low.
  - stable_up, FSM and io_jump stay 0; jump_count stays 0.
- No queueing: second clean press rising during ACTIVE.
  - After ACTIVE ends, FSM returns to IDLE; jump_count=1, not 2.
  - io_jump stays 0 through the next two frames.
- Simultaneous events: up_rise and screen_end on the same edge in IDLE.
  - FSM=ARMED, io_jump=0, jump_count=0.
  - Next screen_end → ACTIVE, jump_count=1.
- Duck priority: down held and debounced (io_duck=1), then an up press goes active.
  - io_duck=0 for the entire ACTIVE frame.
  - io_duck=1 again one edge after ACTIVE exits while down is held.
- Async reset mid-ACTIVE: assert reset between edges.
  - io_jump, io_duck and jump_count are 0 before the next edge.
  - After release with up still held: no jump until up is released and re-pressed.
  - jump_count wraps 255→0 on the 256th jump in a long-run check.
